// File: rtl/gray_ser_pkg.sv
// Shared definitions for the Gray-code serial transmitter.
//   state_e             : transmitter state (IDLE = no frame, SHIFT = frame in flight)
//   GRAY_WIDTH_DEFAULT  : default word width in bits
package gray_ser_pkg;

  localparam int GRAY_WIDTH_DEFAULT = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/gray_ser_tx_bin2gray.sv
// Binary to Gray-code converter (purely combinational).
//   bin_i  [WIDTH-1:0] : binary input word
//   gray_o [WIDTH-1:0] : Gray-coded word, gray = bin ^ (bin >> 1)
module bin2gray #(
  parameter int WIDTH = gray_ser_pkg::GRAY_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_ser_tx.sv
// Gray-code serial transmitter: accepts binary words on a valid/ready
// handshake, converts them to Gray code and shifts them out MSB first.
// Back-to-back words give a gap-free serial stream.
//   clk        : clock, all state on posedge
//   rst        : synchronous active-high reset
//   in_valid   : upstream word present on in_data
//   in_data    : binary word to transmit
//   in_ready   : word accepted this cycle (decoded from registered state only)
//   ser_out    : serial Gray bit, MSB first (0 when idle)
//   ser_valid  : ser_out carries a frame bit
//   ser_first  : high on the MSB of each frame
//   frame_cnt  : completed frames, wraps modulo 256
module gray_ser_tx
  import gray_ser_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic [7:0]       frame_cnt
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [7:0]       frame_q, frame_d;
  logic [WIDTH-1:0] gray_w;
  logic             at_last;
  logic             xfer;

  bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
    .bin_i  (in_data),
    .gray_o (gray_w)
  );

  always_comb begin
    at_last  = (state_q == SHIFT) && (cnt_q == LAST);
    in_ready = (state_q == IDLE) || at_last;
    xfer     = in_valid && in_ready;

    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    frame_d = frame_q;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shreg_d = gray_w;
        end
      end
      SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        if (at_last) begin
          frame_d = frame_q + 8'd1;
          cnt_d   = '0;
          // A word accepted on the final bit reloads straight away so the
          // next frame's MSB follows without an idle cycle.
          if (xfer) begin
            shreg_d = gray_w;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      frame_q <= frame_d;
    end
  end

  assign ser_valid = (state_q == SHIFT);
  assign ser_first = (state_q == SHIFT) && (cnt_q == '0);
  assign ser_out   = (state_q == SHIFT) && shreg_q[WIDTH-1];
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_gray_ser_tx.sv
// Scoreboard bench for gray_ser_tx (WIDTH = 5). Stimulus pushes the expected
// serial bits per accepted word; a negedge monitor pops and compares, decodes
// the serial Gray stream back to binary and checks frame_cnt every cycle.
module tb_gray_ser_tx;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [4:0] in_data;
  logic       in_ready;
  logic       ser_out;
  logic       ser_valid;
  logic       ser_first;
  logic [7:0] frame_cnt;

  gray_ser_tx #(.WIDTH(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_first (ser_first),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic b;
    logic first;
    logic last;
  } exp_t;

  exp_t       exp_q[$];
  logic [4:0] lb_q[$];
  logic [7:0] exp_frames;
  bit         mon_en;
  int         n_checks;
  int         n_fail;

  logic       dec_bit;
  logic [4:0] sipo;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [4:0] b2g(input logic [4:0] w);
    return w ^ (w >> 1);
  endfunction

  // Monitor: one comparison set per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      chk("frame_cnt", {8'h00, frame_cnt}, {8'h00, exp_frames});
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ser_valid", {15'd0, ser_valid}, 16'd1);
        chk("ser_out",   {15'd0, ser_out},   {15'd0, e.b});
        chk("ser_first", {15'd0, ser_first}, {15'd0, e.first});
        chk("in_ready",  {15'd0, in_ready},  {15'd0, e.last});
        dec_bit = e.first ? ser_out : (dec_bit ^ ser_out);
        sipo    = {sipo[3:0], dec_bit};
        if (e.last) begin
          exp_frames = exp_frames + 8'd1;
          if (lb_q.size() > 0) chk("loopback", {11'd0, sipo}, {11'd0, lb_q.pop_front()});
        end
      end else begin
        chk("idle_ser_valid", {15'd0, ser_valid}, 16'd0);
        chk("idle_ser_out",   {15'd0, ser_out},   16'd0);
        chk("idle_ser_first", {15'd0, ser_first}, 16'd0);
        chk("idle_in_ready",  {15'd0, in_ready},  16'd1);
      end
    end
  end

  // Called at posedge+1; waits for in_ready, transfers on the next edge.
  task automatic send(input logic [4:0] w, input logic [4:0] g, input bit hold);
    int k = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 16'd0, 16'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      for (int unsigned i = 0; i < 5; i++)
        exp_q.push_back('{b: g[4-i], first: (i == 0), last: (i == 4)});
      lb_q.push_back(w);
      #1;
      if (!hold) in_valid = 1'b0;
      in_data = ~w;  // frame in flight must ignore later in_data changes
    end
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() > 0 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (exp_q.size() > 0) chk("drain_timeout", 16'd0, 16'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    exp_q.delete();
    lb_q.delete();
    exp_frames = 8'd0;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    mon_en     = 1'b0;
    exp_frames = 8'd0;
    dec_bit    = 1'b0;
    sipo       = '0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ser_valid", {15'd0, ser_valid}, 16'd0);
    chk("rst_ser_out",   {15'd0, ser_out},   16'd0);
    chk("rst_ser_first", {15'd0, ser_first}, 16'd0);
    chk("rst_frame_cnt", {8'd0, frame_cnt},  16'd0);
    chk("rst_in_ready",  {15'd0, in_ready},  16'd1);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Single word 01101 -> gray 01011
    send(5'b01101, 5'b01011, 1'b0);
    drain();
    chk("single_frame_cnt", {8'd0, frame_cnt}, 16'd1);

    // Back-to-back 3 then 4 -> gray 00010, 00110
    send(5'd3, 5'b00010, 1'b1);
    send(5'd4, 5'b00110, 1'b0);
    drain();

    // Boundary values
    send(5'b11111, 5'b10000, 1'b0);
    send(5'b00000, 5'b00000, 1'b0);
    drain();
    chk("boundary_frame_cnt", {8'd0, frame_cnt}, 16'd5);

    // Reset mid-frame during bit 3 of 10101 (gray 11111)
    send(5'b10101, 5'b11111, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    flush();
    chk("midrst_ser_valid", {15'd0, ser_valid}, 16'd0);
    chk("midrst_frame_cnt", {8'd0, frame_cnt},  16'd0);
    chk("midrst_in_ready",  {15'd0, in_ready},  16'd1);
    send(5'b10101, 5'b11111, 1'b0);
    drain();
    chk("postrst_frame_cnt", {8'd0, frame_cnt}, 16'd1);

    // Reset dominates a same-edge transfer: word dropped
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 5'b11011;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    flush();
    repeat (3) @(posedge clk);
    #1;
    chk("rstxfer_frame_cnt", {8'd0, frame_cnt}, 16'd0);

    // Loopback of all 32 values
    for (int v = 0; v < 32; v++) send(5'(v), b2g(5'(v)), 1'b0);
    drain();
    chk("loop_frame_cnt", {8'd0, frame_cnt}, 16'd32);

    // Counter wrap: 255 then 256 frames from reset, streamed back-to-back
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    flush();
    for (int v = 0; v < 255; v++) send(5'(v), b2g(5'(v)), 1'b1);
    in_valid = 1'b0;
    drain();
    chk("wrap_255", {8'd0, frame_cnt}, 16'd255);
    send(5'd9, b2g(5'd9), 1'b0);
    drain();
    chk("wrap_0", {8'd0, frame_cnt}, 16'd0);

    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
